// File: rtl/tx_pkg.sv
// Shared definitions for the serial transmitter: state encoding, default
// frame geometry and line-level constants.
// Optional feature macro: TRANSMITTER_PARITY_EN (adds the PARITY state).
package tx_pkg;

    localparam int DEFAULT_DATA_SIZE  = 8;
    localparam int DEFAULT_OVERSAMPLE = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef TRANSMITTER_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/tx_bit_timer.sv
// Sample counter for one serial bit: counts 0..OVERSAMPLE-1 and raises
// tick on the last sample so the FSM can advance on the bit boundary.
// The running count is also exported so the FSM can anticipate the final
// sample of a bit with a registered output.
module tx_bit_timer #(
    parameter int OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    output logic       tick,
    output logic [3:0] count
);

    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    logic [3:0] r_count;
    logic       w_tick;

    assign w_tick = (r_count == LAST_SAMPLE);
    assign tick   = w_tick;
    assign count  = r_count;

    // Sample counter: held at zero while cleared, wraps on every bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (clear || w_tick) begin
            r_count <= 4'd0;
        end else begin
            r_count <= r_count + 4'd1;
        end
    end

endmodule

// File: rtl/transmitter.sv
// Oversampled serial transmitter: start bit, DATA_SIZE payload bits LSB
// first, optional even parity bit, one stop bit. Each bit lasts OVERSAMPLE
// cycles of bclk_x8. All outputs are registered; rst clears the frame
// asynchronously and forces the line high.
// Optional feature macro: TRANSMITTER_PARITY_EN (inserts an even parity bit
// between the payload and the stop bit).
module transmitter
    import tx_pkg::*;
#(
    parameter int DATA_SIZE  = DEFAULT_DATA_SIZE,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 bclk_x8,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_SIZE-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_status,
    output logic                 flag
);

    localparam int BIT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE - 1);
    // Sample index one before the last; seeing it in STOP means the next
    // cycle is the final period of the frame.
    localparam logic [3:0] PRE_LAST_SAMPLE = 4'(OVERSAMPLE - 2);

    tx_state_t            r_state;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_SIZE-1:0] r_shreg;
    logic                 r_tx_out;
    logic                 r_tx_status;
    logic                 r_tx_ready;
    logic                 r_flag;
`ifdef TRANSMITTER_PARITY_EN
    logic                 r_parity;
`endif

    logic                 w_tick;
    logic [3:0]           w_count;
    logic                 w_timer_clear;
    logic [DATA_SIZE-1:0] w_shift_next;

    // The sample counter rests at zero in IDLE so START begins on a clean
    // bit boundary the cycle after acceptance.
    assign w_timer_clear = (r_state == IDLE);
    assign w_shift_next  = r_shreg >> 1;

    tx_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk  (bclk_x8),
        .rst  (rst),
        .clear(w_timer_clear),
        .tick (w_tick),
        .count(w_count)
    );

    assign tx_out    = r_tx_out;
    assign tx_ready  = r_tx_ready;
    assign tx_status = r_tx_status;
    assign flag      = r_flag;

    // Frame sequencer: state, payload shift register and registered outputs.
    always_ff @(posedge bclk_x8 or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_tx_out    <= STOP_BIT;
            r_tx_status <= 1'b0;
            r_tx_ready  <= 1'b1;
            r_flag      <= 1'b0;
`ifdef TRANSMITTER_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_flag <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_state     <= START;
                        r_shreg     <= tx_data;
                        r_bit_cnt   <= '0;
                        r_tx_out    <= START_BIT;
                        r_tx_status <= 1'b1;
                        r_tx_ready  <= 1'b0;
`ifdef TRANSMITTER_PARITY_EN
                        r_parity    <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state  <= DATA;
                        r_tx_out <= r_shreg[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shreg <= w_shift_next;
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef TRANSMITTER_PARITY_EN
                            r_state  <= PARITY;
                            r_tx_out <= r_parity;
`else
                            r_state  <= STOP;
                            r_tx_out <= STOP_BIT;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tx_out  <= w_shift_next[0];
                        end
                    end
                end
`ifdef TRANSMITTER_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_state  <= STOP;
                        r_tx_out <= STOP_BIT;
                    end
                end
`endif
                STOP: begin
                    r_flag <= (w_count == PRE_LAST_SAMPLE);
                    if (w_tick) begin
                        r_state     <= IDLE;
                        r_tx_status <= 1'b0;
                        r_tx_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_tx_out    <= STOP_BIT;
                    r_tx_status <= 1'b0;
                    r_tx_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
